// File: rtl/dual_issue_pkg.sv
// Shared types for the dual-issue scheduler: instruction record, FSM states and
// the hard-wired zero register.
package dual_issue_pkg;

    localparam int PKG_REG_W = 4;
    localparam int PKG_OP_W  = 4;

    localparam logic [PKG_REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [PKG_OP_W-1:0]  op;
        logic [PKG_REG_W-1:0] des;
        logic [PKG_REG_W-1:0] s1;
        logic [PKG_REG_W-1:0] s2;
    } instr_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_e;

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational RAW/WAW/WAR check between the two queue heads; register 0
// never creates a dependency.
module pair_hazard_check
    import dual_issue_pkg::*;
(
    input  instr_t head0_i,
    input  instr_t head1_i,
    output logic   pair_hz_o
);

    logic w0, w1;
    logic hz_from0, hz_from1;
    logic unused_op;

    assign w0 = (head0_i.des != REG_ZERO);
    assign w1 = (head1_i.des != REG_ZERO);

    // Older write seen by younger read/write (RAW, WAW).
    assign hz_from0 = w0 & ((head0_i.des == head1_i.s1) |
                            (head0_i.des == head1_i.s2) |
                            (head0_i.des == head1_i.des));

    // Younger write would clobber an operand the older one still reads (WAR).
    assign hz_from1 = w1 & ((head1_i.des == head0_i.s1) |
                            (head1_i.des == head0_i.s2));

    assign pair_hz_o = hz_from0 | hz_from1;

    assign unused_op = ^{head0_i.op, head1_i.op};

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: hazard screening, busy-register scoreboard,
// registered issue slots with handshakes, flush FSM and stall counter.
module dual_issue_scheduler
    import dual_issue_pkg::*;
#(
    parameter int REG_W     = 4,
    parameter int OP_W      = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  dual_en,
    input  logic                  q_valid0,
    input  logic                  q_valid1,
    input  logic [OP_W-1:0]       q_op0,
    input  logic [OP_W-1:0]       q_op1,
    input  logic [REG_W-1:0]      q_des0,
    input  logic [REG_W-1:0]      q_des1,
    input  logic [REG_W-1:0]      q_s10,
    input  logic [REG_W-1:0]      q_s20,
    input  logic [REG_W-1:0]      q_s11,
    input  logic [REG_W-1:0]      q_s21,
    output logic [1:0]            q_deq,
    output logic                  iss_valid0,
    output logic                  iss_valid1,
    output logic [OP_W-1:0]       iss_op0,
    output logic [OP_W-1:0]       iss_op1,
    output logic [REG_W-1:0]      iss_des0,
    output logic [REG_W-1:0]      iss_des1,
    output logic [REG_W-1:0]      iss_s10,
    output logic [REG_W-1:0]      iss_s20,
    output logic [REG_W-1:0]      iss_s11,
    output logic [REG_W-1:0]      iss_s21,
    input  logic                  iss_ready0,
    input  logic                  iss_ready1,
    input  logic                  wb_valid0,
    input  logic                  wb_valid1,
    input  logic [REG_W-1:0]      wb_des0,
    input  logic [REG_W-1:0]      wb_des1,
    output logic [2**REG_W-1:0]   busy_vec,
    output logic [15:0]           stall_cnt
);

    localparam int NREG = 2**REG_W;

    sched_state_e    state_q, state_d;
    logic [3:0]      fcnt_q, fcnt_d;
    instr_t          slot0_q, slot0_d, slot1_q, slot1_d;
    logic            v0_q, v0_d, v1_q, v1_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [15:0]     stall_q, stall_d;

    instr_t head0, head1;
    logic   pair_hz, adv, run, issue_en, ok0, ok1, iss0, iss1;

    function automatic logic is_busy(input logic [NREG-1:0] vec, input logic [REG_W-1:0] r);
        return vec[r] & (r != REG_ZERO);
    endfunction

    assign head0 = {q_op0, q_des0, q_s10, q_s20};
    assign head1 = {q_op1, q_des1, q_s11, q_s21};

    pair_hazard_check u_pair_hz (
        .head0_i   (head0),
        .head1_i   (head1),
        .pair_hz_o (pair_hz)
    );

    assign adv = (!v0_q | iss_ready0) & (!v1_q | iss_ready1);
    assign run = (state_q == RUN);

    assign ok0 = q_valid0 & !is_busy(busy_q, q_s10) & !is_busy(busy_q, q_s20)
                          & !is_busy(busy_q, q_des0);
    assign ok1 = ok0 & dual_en & q_valid1 & !pair_hz & !is_busy(busy_q, q_s11)
                     & !is_busy(busy_q, q_s21) & !is_busy(busy_q, q_des1);

    // Flush and reset both suppress dequeue in the cycle they are asserted.
    assign issue_en = rst_n & run & !flush & adv;
    assign iss0     = issue_en & ok0;
    assign iss1     = issue_en & ok1;
    assign q_deq    = {1'b0, iss0} + {1'b0, iss1};

    // Per-register scoreboard update: writeback clears, issue sets, set wins.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                logic wb_hit, iss_hit;
                assign wb_hit  = (wb_valid0 & (wb_des0 == REG_W'(gi))) |
                                 (wb_valid1 & (wb_des1 == REG_W'(gi)));
                assign iss_hit = (iss0 & (q_des0 == REG_W'(gi))) |
                                 (iss1 & (q_des1 == REG_W'(gi)));
                assign busy_d[gi] = flush ? 1'b0 :
                                    run   ? ((busy_q[gi] & ~wb_hit) | iss_hit) :
                                            busy_q[gi];
            end
        end
    endgenerate

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        if (flush) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else if (adv) begin
            if (run) begin
                slot0_d = head0;
                slot1_d = head1;
                v0_d    = ok0;
                v1_d    = ok1;
            end else begin
                v0_d = 1'b0;
                v1_d = 1'b0;
            end
        end
    end

    // Counter reaching zero at an edge means the following cycle is RUN.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (flush) begin
            state_d = FLUSH;
            fcnt_d  = 4'(FLUSH_CYC);
        end else if (state_q == FLUSH) begin
            if (fcnt_q != 4'd0) begin
                fcnt_d = fcnt_q - 4'd1;
            end
            if (fcnt_q <= 4'd1) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (run && q_valid0 && (q_deq == 2'd0) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            slot0_q <= '0;
            slot1_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign iss_valid0 = v0_q;
    assign iss_valid1 = v1_q;
    assign iss_op0    = slot0_q.op;
    assign iss_des0   = slot0_q.des;
    assign iss_s10    = slot0_q.s1;
    assign iss_s20    = slot0_q.s2;
    assign iss_op1    = slot1_q.op;
    assign iss_des1   = slot1_q.des;
    assign iss_s11    = slot1_q.s1;
    assign iss_s21    = slot1_q.s2;
    assign busy_vec   = busy_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench: stimulus pushes expected issued instructions ({op,des,s1,s2}
// nibbles) into a queue; a negedge monitor pops and compares on each slot transfer.
module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        dual_en = 1'b1;
    logic        q_valid0 = 1'b0, q_valid1 = 1'b0;
    logic [3:0]  q_op0 = '0, q_op1 = '0, q_des0 = '0, q_des1 = '0;
    logic [3:0]  q_s10 = '0, q_s20 = '0, q_s11 = '0, q_s21 = '0;
    logic [1:0]  q_deq;
    logic        iss_valid0, iss_valid1;
    logic [3:0]  iss_op0, iss_op1, iss_des0, iss_des1;
    logic [3:0]  iss_s10, iss_s20, iss_s11, iss_s21;
    logic        iss_ready0 = 1'b1, iss_ready1 = 1'b1;
    logic        wb_valid0 = 1'b0, wb_valid1 = 1'b0;
    logic [3:0]  wb_des0 = '0, wb_des1 = '0;
    logic [15:0] busy_vec;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    dual_issue_scheduler #(.REG_W(4), .OP_W(4), .FLUSH_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .dual_en    (dual_en),
        .q_valid0   (q_valid0),
        .q_valid1   (q_valid1),
        .q_op0      (q_op0),
        .q_op1      (q_op1),
        .q_des0     (q_des0),
        .q_des1     (q_des1),
        .q_s10      (q_s10),
        .q_s20      (q_s20),
        .q_s11      (q_s11),
        .q_s21      (q_s21),
        .q_deq      (q_deq),
        .iss_valid0 (iss_valid0),
        .iss_valid1 (iss_valid1),
        .iss_op0    (iss_op0),
        .iss_op1    (iss_op1),
        .iss_des0   (iss_des0),
        .iss_des1   (iss_des1),
        .iss_s10    (iss_s10),
        .iss_s20    (iss_s20),
        .iss_s11    (iss_s11),
        .iss_s21    (iss_s21),
        .iss_ready0 (iss_ready0),
        .iss_ready1 (iss_ready1),
        .wb_valid0  (wb_valid0),
        .wb_valid1  (wb_valid1),
        .wb_des0    (wb_des0),
        .wb_des1    (wb_des1),
        .busy_vec   (busy_vec),
        .stall_cnt  (stall_cnt)
    );

    int          total_cnt = 0;
    int          pass_cnt = 0;
    int          exp_stall = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic        mon_adv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic heads(input logic v0, input logic [15:0] i0, input logic v1, input logic [15:0] i1);
        q_valid0 = v0;
        {q_op0, q_des0, q_s10, q_s20} = i0;
        q_valid1 = v1;
        {q_op1, q_des1, q_s11, q_s21} = i1;
    endtask

    task automatic wb(input logic v0, input logic [3:0] d0, input logic v1, input logic [3:0] d1);
        wb_valid0 = v0; wb_des0 = d0;
        wb_valid1 = v1; wb_des1 = d1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic deq(input string name, input int req);
        #1;
        check(name, 32'(q_deq), 32'(req));
    endtask

    // Monitor: a slot transfers when its valid is up and the slot pair advances.
    assign mon_adv = (!iss_valid0 | iss_ready0) & (!iss_valid1 | iss_ready1);

    always @(negedge clk) begin
        if (rst_n && mon_adv) begin
            if (iss_valid0) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL slot0_unexpected: got 0x%0h required no issue",
                             {iss_op0, iss_des0, iss_s10, iss_s20});
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("slot0_instr", 32'({iss_op0, iss_des0, iss_s10, iss_s20}), 32'(mon_exp));
                end
            end
            if (iss_valid1) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL slot1_unexpected: got 0x%0h required no issue",
                             {iss_op1, iss_des1, iss_s11, iss_s21});
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("slot1_instr", 32'({iss_op1, iss_des1, iss_s11, iss_s21}), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        // Reset with valid heads presented: nothing may dequeue
        heads(1, 16'h1123, 1, 16'h2456);
        nxt(); nxt();
        check("reset_valid", 32'({iss_valid1, iss_valid0}), 32'd0);
        check("reset_busy", 32'(busy_vec), 32'd0);
        check("reset_stall", 32'(stall_cnt), 32'd0);
        check("reset_fields", 32'({iss_op0, iss_des0, iss_s10, iss_s20, iss_op1, iss_des1, iss_s11, iss_s21}), 32'd0);
        deq("deq_in_reset", 0);
        rst_n = 1'b1;

        // Independent pair
        deq("deq_indep_pair", 2);
        exp_q.push_back(16'h1123); exp_q.push_back(16'h2456);
        nxt();
        check("busy_after_pair", 32'(busy_vec), 32'h0012);
        check("dual_valid", 32'({iss_valid1, iss_valid0}), 32'd3);
        heads(0, 16'h0, 0, 16'h0);
        wb(1, 4'd1, 1, 4'd4);
        nxt();
        check("busy_after_wb", 32'(busy_vec), 32'h0000);
        check("slots_idle", 32'({iss_valid1, iss_valid0}), 32'd0);
        wb(0, 4'd0, 0, 4'd0);

        // RAW inside the pair
        heads(1, 16'h3312, 1, 16'h4530);
        deq("deq_raw_pair", 1);
        exp_q.push_back(16'h3312);
        nxt();
        check("raw_slot0_only", 32'({iss_valid1, iss_valid0}), 32'd1);
        heads(1, 16'h4530, 0, 16'h0);
        wb(1, 4'd3, 0, 4'd0);
        deq("deq_src_busy", 0);
        exp_stall++;
        nxt();
        wb(0, 4'd0, 0, 4'd0);
        deq("deq_after_wb3", 1);
        exp_q.push_back(16'h4530);
        nxt();
        check("busy_reg5", 32'(busy_vec), 32'h0020);

        // Scoreboard stall on source 5
        heads(1, 16'h5615, 0, 16'h0);
        deq("deq_sb_stall_a", 0);
        exp_stall++;
        nxt();
        check("stall_cnt_sb", 32'(stall_cnt), 32'(exp_stall));
        wb(1, 4'd5, 0, 4'd0);
        deq("deq_sb_stall_b", 0);
        exp_stall++;
        nxt();
        wb(0, 4'd0, 0, 4'd0);
        deq("deq_sb_release", 1);
        exp_q.push_back(16'h5615);
        nxt();
        check("busy_reg6", 32'(busy_vec), 32'h0040);
        heads(0, 16'h0, 0, 16'h0);
        wb(0, 4'd0, 1, 4'd6);
        nxt();
        check("busy_clear6", 32'(busy_vec), 32'h0000);
        wb(0, 4'd0, 0, 4'd0);

        // Backpressure on slot 0 for three cycles
        heads(1, 16'h7211, 1, 16'h8000);
        deq("deq_pre_bp", 2);
        exp_q.push_back(16'h7211); exp_q.push_back(16'h8000);
        nxt();
        for (int k = 0; k < 3; k++) begin
            iss_ready0 = 1'b0;
            heads(1, 16'h9300, 0, 16'h0);
            deq("deq_backpressure", 0);
            exp_stall++;
            check("slot0_hold", 32'({iss_valid0, iss_op0, iss_des0, iss_s10, iss_s20}), 32'h17211);
            nxt();
        end
        iss_ready0 = 1'b1;
        deq("deq_reload", 1);
        exp_q.push_back(16'h9300);
        nxt();
        check("busy_reg2_3", 32'(busy_vec), 32'h000C);
        check("stall_cnt_bp", 32'(stall_cnt), 32'(exp_stall));

        // Flush with slot 0 valid and busy bits set; the held instruction is killed
        iss_ready0 = 1'b0;
        flush = 1'b1;
        heads(1, 16'hA400, 0, 16'h0);
        deq("deq_flush_cycle", 0);
        exp_stall++;
        void'(exp_q.pop_back());
        nxt();
        flush = 1'b0;
        iss_ready0 = 1'b1;
        check("flush_valid", 32'({iss_valid1, iss_valid0}), 32'd0);
        check("flush_busy", 32'(busy_vec), 32'h0000);
        wb(1, 4'd4, 1, 4'd3);
        deq("deq_flush_1", 0);
        nxt();
        wb(0, 4'd0, 0, 4'd0);
        check("busy_wb_in_flush", 32'(busy_vec), 32'h0000);
        deq("deq_flush_2", 0);
        nxt();
        deq("deq_resume", 1);
        exp_q.push_back(16'hA400);
        nxt();
        check("busy_reg4", 32'(busy_vec), 32'h0010);
        heads(0, 16'h0, 0, 16'h0);
        wb(1, 4'd4, 0, 4'd0);
        nxt();
        wb(0, 4'd0, 0, 4'd0);

        // Register 0 everywhere: no hazard, dual issue
        heads(1, 16'hB000, 1, 16'hC000);
        deq("deq_des_zero", 2);
        exp_q.push_back(16'hB000); exp_q.push_back(16'hC000);
        nxt();
        check("busy_des_zero", 32'(busy_vec), 32'h0000);

        // Dual issue disabled on an independent pair
        dual_en = 1'b0;
        heads(1, 16'hD912, 1, 16'hE834);
        deq("deq_dual_dis", 1);
        exp_q.push_back(16'hD912);
        nxt();
        check("busy_reg9", 32'(busy_vec), 32'h0200);

        // Same-cycle writeback and issue on reg 7; wb clears reg 9
        dual_en = 1'b1;
        heads(1, 16'hF700, 0, 16'h0);
        wb(1, 4'd7, 1, 4'd9);
        deq("deq_set_vs_clr", 1);
        exp_q.push_back(16'hF700);
        nxt();
        check("busy_set_wins", 32'(busy_vec), 32'h0080);
        check("stall_cnt_final", 32'(stall_cnt), 32'(exp_stall));
        heads(0, 16'h0, 0, 16'h0);
        wb(0, 4'd0, 0, 4'd0);
        nxt(); nxt();
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
